bias_replay_sequencer: RTL

Layer-level sequencer for the bias buffer. It accepts one layer's bias words from the read-DMA stream and writes them into a single-port synchronous bias BRAM that it owns. It then replays the full bias set once per output tile to the convolution engine over a valid/ready stream. It sits between the RDMA bias channel and the conv datapath, and is started once per layer by the layer controller.

---
 rtl/bias_replay_sequencer.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/bias_replay_sequencer.sv
// Bias buffer sequencer: loads one layer's bias set into BRAM,
// then replays it once per output tile to the conv engine.
module bias_replay_sequencer #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [31:0]           transfer_byte,
  input  logic [15:0]           num_tiles,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic                  bram_we,
  output logic [DATA_WIDTH-1:0] bram_din,
  input  logic [DATA_WIDTH-1:0] bram_dout,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready
);

  localparam logic [32:0] DEPTH = 33'(2 ** ADDR_WIDTH);

  typedef enum logic [2:0] {
    IDLE, LOAD, REPLAY, FLUSH, DONE
  } state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   wr_ptr;
  logic [ADDR_WIDTH-1:0]   rd_ptr;
  logic [ADDR_WIDTH-1:0]   last_idx;
  logic [15:0]             tiles_r;
  logic [15:0]             tile_cnt;
  logic                    err_r;
  logic                    inflight;
  logic [DATA_WIDTH-1:0]   fifo [3];
  logic [1:0]              f_wp;
  logic [1:0]              f_rp;
  logic [1:0]              f_cnt;

  logic [32:0] beats;
  logic        bad_len;
  logic        last_wr;
  logic        last_tile;
  logic        issue;
  logic        push;
  logic        pop;
  logic        drained;

  assign beats     = ({1'b0, transfer_byte} + 33'd7) >> 3;
  assign bad_len   = (beats == 33'd0) || (beats > DEPTH);
  assign last_wr   = wr_ptr == last_idx;
  assign last_tile = tile_cnt == tiles_r - 16'd1;
  // Occupancy is registered, so issue never depends on m_ready.
  assign issue     = (state == REPLAY) &&
                     (({1'b0, f_cnt} + {2'b00, inflight}) < 3'd3);
  assign push      = inflight;
  assign pop       = (f_cnt != 2'd0) && m_ready;
  assign drained   = !inflight &&
                     ((f_cnt == 2'd0) || ((f_cnt == 2'd1) && pop));

  assign busy     = state != IDLE;
  assign done     = state == DONE;
  assign err      = (state == DONE) && err_r;
  assign s_ready  = state == LOAD;
  assign bram_we  = (state == LOAD) && s_valid;
  assign bram_din = s_data;
  assign m_valid  = f_cnt != 2'd0;
  assign m_data   = fifo[f_rp];

  always_comb begin
    bram_addr = '0;
    unique case (1'b1)
      state == LOAD:   bram_addr = wr_ptr;
      state == REPLAY: bram_addr = rd_ptr;
      default: ;
    endcase
  end

  function automatic logic [1:0] nxt(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      last_idx <= '0;
      tiles_r  <= '0;
      tile_cnt <= '0;
      err_r    <= 1'b0;
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
      unique case (state)
        IDLE: if (start) begin
          wr_ptr   <= '0;
          rd_ptr   <= '0;
          tile_cnt <= '0;
          if (bad_len) begin
            err_r <= 1'b1;
            state <= DONE;
          end else begin
            err_r    <= 1'b0;
            last_idx <= ADDR_WIDTH'(beats - 33'd1);
            tiles_r  <= num_tiles;
            state    <= LOAD;
          end
        end
        LOAD: if (s_valid) begin
          wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
          if (last_wr)
            state <= (tiles_r == 16'd0) ? DONE : REPLAY;
        end
        REPLAY: if (issue) begin
          if (rd_ptr == last_idx) begin
            rd_ptr   <= '0;
            tile_cnt <= tile_cnt + 16'd1;
            if (last_tile) state <= FLUSH;
          end else begin
            rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
          end
        end
        FLUSH: if (drained) state <= DONE;
        DONE: begin
          err_r <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Read data lands in the FIFO the cycle after its address was issued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) fifo[i] <= '0;
      f_wp  <= '0;
      f_rp  <= '0;
      f_cnt <= '0;
    end else begin
      if (push) begin
        fifo[f_wp] <= bram_dout;
        f_wp       <= nxt(f_wp);
      end
      if (pop) f_rp <= nxt(f_rp);
      if (push && !pop)      f_cnt <= f_cnt + 2'd1;
      else if (pop && !push) f_cnt <= f_cnt - 2'd1;
    end
  end

endmodule
